mem_access_unit: RTL and testbench

//  MEM stage of the 5-stage MIPS pipeline; consumes the EX/MEM register bundle.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/mem_access_unit_mem_wb.sv | 18 +
 rtl/mem_access_unit.sv | 161 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types for the MIPS pipeline MEM stage.
// Holds the FSM state encoding and the MEM/WB bundle layout.
package mips_pkg;

  localparam int WORD_W   = 32;
  localparam int REG_AW   = 5;
  localparam int ADDR_LSB = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic              halt;
    logic [REG_AW-1:0] reg_dst;
    logic [WORD_W-1:0] alu_out;
    logic [WORD_W-1:0] rdata;
    logic [WORD_W-1:0] pc;
  } mem_wb_t;

endpackage

// File: rtl/mem_access_unit_mem_wb.sv
// MEM/WB pipeline register.
// Loads the prepared bundle every cycle; the MEM FSM decides its contents.
module mem_wb
  import mips_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  mem_wb_t d,
  output mem_wb_t q
);

  // plain register with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: word load/store over a req/ack RAM handshake.
// Stalls upstream while an access is in flight, then retires to MEM/WB.
module mem_access_unit
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_ex_mem,
  input  logic [31:0] instruction_ex_mem,
  input  logic        RegWrite_ex_mem,
  input  logic        RegDst_ex_mem,
  input  logic        MemRead_ex_mem,
  input  logic        MemWrite_ex_mem,
  input  logic        MemtoReg_ex_mem,
  input  logic [31:0] alu_out_ex_mem,
  input  logic [31:0] ram_write_data_ex_mem,
  input  logic [4:0]  rt_ex_mem,
  input  logic [4:0]  rd_ex_mem,
  input  logic        halt_ex_mem,
  output logic        ram_req,
  output logic        ram_we,
  output logic [29:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic        ram_ack,
  input  logic [31:0] ram_rdata,
  output logic        mem_stall,
  output logic        RegWrite_mem_wb,
  output logic        MemtoReg_mem_wb,
  output logic        halt_mem_wb,
  output logic [4:0]  reg_dst_mem_wb,
  output logic [31:0] alu_out_mem_wb,
  output logic [31:0] ram_rdata_mem_wb,
  output logic [31:0] pc_mem_wb,
  output logic        misalign_err,
  output logic        timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  mem_state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic req_n, we_n, mis_n, to_n;
  logic [29:0] addr_n;
  logic [31:0] wdata_n;
  logic is_mem, mem_op, misalign, timeout_hit;
  mem_wb_t wb_full, wb_d, wb_q;

  // instruction word is carried for debug only
  logic unused_instr;
  assign unused_instr = ^instruction_ex_mem;

  assign is_mem   = MemRead_ex_mem | MemWrite_ex_mem;
  assign misalign = is_mem & (alu_out_ex_mem[ADDR_LSB-1:0] != '0);
  assign mem_op   = is_mem & ~halt_ex_mem & ~misalign;

  assign timeout_hit = (state == BUSY) & ~ram_ack
                     & (cnt == CNT_W'(TIMEOUT_CYC - 1));

  assign mem_stall = ((state == IDLE) & mem_op)
                   | ((state == BUSY) & ~ram_ack & ~timeout_hit);

  // full bundle as it would retire without RAM data
  always_comb begin
    wb_full            = '0;
    wb_full.reg_write  = RegWrite_ex_mem;
    wb_full.mem_to_reg = MemtoReg_ex_mem;
    wb_full.halt       = halt_ex_mem;
    wb_full.reg_dst    = RegDst_ex_mem ? rd_ex_mem : rt_ex_mem;
    wb_full.alu_out    = alu_out_ex_mem;
    wb_full.pc         = pc_ex_mem;
  end

  // next-state, handshake and MEM/WB selection
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    req_n   = ram_req;
    we_n    = ram_we;
    addr_n  = ram_addr;
    wdata_n = ram_wdata;
    mis_n   = misalign_err;
    to_n    = timeout_err;
    wb_d    = '0;
    unique case (state)
      IDLE: begin
        if (mem_op) begin
          req_n   = 1'b1;
          we_n    = MemWrite_ex_mem & ~MemRead_ex_mem;
          addr_n  = alu_out_ex_mem[31:ADDR_LSB];
          wdata_n = ram_write_data_ex_mem;
          cnt_n   = '0;
          state_n = BUSY;
        end else begin
          wb_d = wb_full;
          if (misalign) begin
            mis_n          = 1'b1;
            wb_d.reg_write = 1'b0;
          end
        end
      end
      BUSY: begin
        if (ram_ack) begin
          req_n      = 1'b0;
          wb_d       = wb_full;
          wb_d.rdata = ram_we ? '0 : ram_rdata;
          state_n    = IDLE;
        end else if (timeout_hit) begin
          req_n          = 1'b0;
          to_n           = 1'b1;
          wb_d           = wb_full;
          wb_d.reg_write = 1'b0;
          state_n        = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // state, RAM interface and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      ram_req      <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      ram_req      <= req_n;
      ram_we       <= we_n;
      ram_addr     <= addr_n;
      ram_wdata    <= wdata_n;
      misalign_err <= mis_n;
      timeout_err  <= to_n;
    end
  end

  mem_wb u_mem_wb (
    .clk (clk),
    .rst (rst),
    .d   (wb_d),
    .q   (wb_q)
  );

  assign RegWrite_mem_wb  = wb_q.reg_write;
  assign MemtoReg_mem_wb  = wb_q.mem_to_reg;
  assign halt_mem_wb      = wb_q.halt;
  assign reg_dst_mem_wb   = wb_q.reg_dst;
  assign alu_out_mem_wb   = wb_q.alu_out;
  assign ram_rdata_mem_wb = wb_q.rdata;
  assign pc_mem_wb        = wb_q.pc;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for the MEM stage.
// Each task drives one scenario and checks it inline.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, instr, alu, wdat, rdata;
  logic        rw, rdst, mr, mw, m2r, halt, ack;
  logic [4:0]  rt, rd;
  logic        ram_req, ram_we, mem_stall;
  logic [29:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        rw_wb, m2r_wb, halt_wb, mis_err, to_err;
  logic [4:0]  dst_wb;
  logic [31:0] alu_wb, rdata_wb, pc_wb;

  int total = 0;
  int bad   = 0;
  int stalls;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYC(4)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .pc_ex_mem             (pc),
    .instruction_ex_mem    (instr),
    .RegWrite_ex_mem       (rw),
    .RegDst_ex_mem         (rdst),
    .MemRead_ex_mem        (mr),
    .MemWrite_ex_mem       (mw),
    .MemtoReg_ex_mem       (m2r),
    .alu_out_ex_mem        (alu),
    .ram_write_data_ex_mem (wdat),
    .rt_ex_mem             (rt),
    .rd_ex_mem             (rd),
    .halt_ex_mem           (halt),
    .ram_req               (ram_req),
    .ram_we                (ram_we),
    .ram_addr              (ram_addr),
    .ram_wdata             (ram_wdata),
    .ram_ack               (ack),
    .ram_rdata             (rdata),
    .mem_stall             (mem_stall),
    .RegWrite_mem_wb       (rw_wb),
    .MemtoReg_mem_wb       (m2r_wb),
    .halt_mem_wb           (halt_wb),
    .reg_dst_mem_wb        (dst_wb),
    .alu_out_mem_wb        (alu_wb),
    .ram_rdata_mem_wb      (rdata_wb),
    .pc_mem_wb             (pc_wb),
    .misalign_err          (mis_err),
    .timeout_err           (to_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    pc = 0; instr = 0; alu = 0; wdat = 0; rdata = 0;
    rw = 0; rdst = 0; mr = 0; mw = 0; m2r = 0; halt = 0;
    ack = 0; rt = 0; rd = 0;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1;
    tick(); tick();
    total++; if (ram_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0b exp=0", ram_req); end
    total++; if (rw_wb !== 1'b0) begin bad++; $display("FAIL rst_rw got=%0b exp=0", rw_wb); end
    total++; if (alu_wb !== 32'h0) begin bad++; $display("FAIL rst_alu got=%h exp=0", alu_wb); end
    total++; if ({mis_err, to_err} !== 2'b00) begin bad++; $display("FAIL rst_flags got=%b exp=00", {mis_err, to_err}); end
    total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0b exp=0", mem_stall); end
    rst = 0;
    tick();
  endtask

  task automatic test_add();
    set_idle();
    rw = 1; rdst = 1; rd = 5; rt = 3; alu = 32'h1234; pc = 32'h40; instr = 32'h00a31020;
    #1;
    total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL add_stall got=%0b exp=0", mem_stall); end
    tick();
    set_idle();
    total++; if (rw_wb !== 1'b1) begin bad++; $display("FAIL add_rw got=%0b exp=1", rw_wb); end
    total++; if (alu_wb !== 32'h1234) begin bad++; $display("FAIL add_alu got=%h exp=1234", alu_wb); end
    total++; if (dst_wb !== 5'd5) begin bad++; $display("FAIL add_dst got=%0d exp=5", dst_wb); end
    total++; if (pc_wb !== 32'h40) begin bad++; $display("FAIL add_pc got=%h exp=40", pc_wb); end
    total++; if (ram_req !== 1'b0) begin bad++; $display("FAIL add_req got=%0b exp=0", ram_req); end
  endtask

  task automatic test_lw();
    set_idle();
    mr = 1; m2r = 1; rw = 1; rt = 7; rd = 9; alu = 32'h100; pc = 32'h80;
    stalls = 0;
    #1;
    if (mem_stall === 1'b1) stalls++;
    tick();
    total++; if (ram_req !== 1'b1 || ram_we !== 1'b0) begin bad++; $display("FAIL lw_req got=%0b/%0b exp=1/0", ram_req, ram_we); end
    total++; if (ram_addr !== 30'h40) begin bad++; $display("FAIL lw_addr got=%h exp=40", ram_addr); end
    total++; if (rw_wb !== 1'b0) begin bad++; $display("FAIL lw_bubble got=%0b exp=0", rw_wb); end
    for (int i = 0; i < 2; i++) begin
      if (mem_stall === 1'b1) stalls++;
      tick();
    end
    ack = 1; rdata = 32'hCAFEF00D;
    #1;
    if (mem_stall === 1'b1) stalls++;
    total++; if (stalls !== 3) begin bad++; $display("FAIL lw_stalls got=%0d exp=3", stalls); end
    tick();
    set_idle();
    total++; if (rw_wb !== 1'b1 || m2r_wb !== 1'b1) begin bad++; $display("FAIL lw_ctl got=%0b%0b exp=11", rw_wb, m2r_wb); end
    total++; if (rdata_wb !== 32'hCAFEF00D) begin bad++; $display("FAIL lw_data got=%h exp=cafef00d", rdata_wb); end
    total++; if (dst_wb !== 5'd7) begin bad++; $display("FAIL lw_dst got=%0d exp=7", dst_wb); end
    total++; if (ram_req !== 1'b0) begin bad++; $display("FAIL lw_reqdrop got=%0b exp=0", ram_req); end
  endtask

  task automatic test_sw();
    set_idle();
    mw = 1; alu = 32'h8; wdat = 32'hDEADBEEF; pc = 32'hC0;
    stalls = 0;
    #1;
    if (mem_stall === 1'b1) stalls++;
    tick();
    total++; if (ram_req !== 1'b1 || ram_we !== 1'b1) begin bad++; $display("FAIL sw_req got=%0b/%0b exp=1/1", ram_req, ram_we); end
    total++; if (ram_addr !== 30'h2) begin bad++; $display("FAIL sw_addr got=%h exp=2", ram_addr); end
    ack = 1; rdata = 32'h11111111;
    #1;
    if (mem_stall === 1'b1) stalls++;
    total++; if (ram_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_wdata got=%h exp=deadbeef", ram_wdata); end
    total++; if (stalls !== 1) begin bad++; $display("FAIL sw_stalls got=%0d exp=1", stalls); end
    tick();
    set_idle();
    total++; if (ram_req !== 1'b0) begin bad++; $display("FAIL sw_reqdrop got=%0b exp=0", ram_req); end
    total++; if (rdata_wb !== 32'h0) begin bad++; $display("FAIL sw_rdata got=%h exp=0", rdata_wb); end
  endtask

  task automatic test_misalign();
    set_idle();
    mr = 1; rw = 1; alu = 32'h102;
    #1;
    total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL mis_stall got=%0b exp=0", mem_stall); end
    tick();
    set_idle();
    total++; if (ram_req !== 1'b0) begin bad++; $display("FAIL mis_req got=%0b exp=0", ram_req); end
    total++; if (mis_err !== 1'b1) begin bad++; $display("FAIL mis_err got=%0b exp=1", mis_err); end
    total++; if (rw_wb !== 1'b0) begin bad++; $display("FAIL mis_rw got=%0b exp=0", rw_wb); end
    tick();
    total++; if (mis_err !== 1'b1) begin bad++; $display("FAIL mis_sticky got=%0b exp=1", mis_err); end
  endtask

  task automatic test_halt();
    set_idle();
    halt = 1; mr = 1; alu = 32'h10; pc = 32'h200;
    #1;
    total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL halt_stall got=%0b exp=0", mem_stall); end
    tick();
    set_idle();
    total++; if (ram_req !== 1'b0) begin bad++; $display("FAIL halt_req got=%0b exp=0", ram_req); end
    total++; if (halt_wb !== 1'b1) begin bad++; $display("FAIL halt_wb got=%0b exp=1", halt_wb); end
  endtask

  task automatic test_timeout();
    set_idle();
    mr = 1; rw = 1; rt = 2; alu = 32'h200;
    tick();
    total++; if (ram_req !== 1'b1) begin bad++; $display("FAIL to_req got=%0b exp=1", ram_req); end
    for (int i = 0; i < 3; i++) begin
      total++; if (mem_stall !== 1'b1) begin bad++; $display("FAIL to_stall%0d got=%0b exp=1", i, mem_stall); end
      tick();
    end
    total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL to_stall_last got=%0b exp=0", mem_stall); end
    tick();
    set_idle();
    total++; if (ram_req !== 1'b0) begin bad++; $display("FAIL to_reqdrop got=%0b exp=0", ram_req); end
    total++; if (to_err !== 1'b1) begin bad++; $display("FAIL to_err got=%0b exp=1", to_err); end
    total++; if (rw_wb !== 1'b0) begin bad++; $display("FAIL to_rw got=%0b exp=0", rw_wb); end
  endtask

  task automatic test_ack_idle();
    set_idle();
    ack = 1; rdata = 32'h55;
    tick();
    set_idle();
    total++; if (rdata_wb !== 32'h0 || ram_req !== 1'b0) begin bad++; $display("FAIL ackidle got=%h/%0b exp=0/0", rdata_wb, ram_req); end
  endtask

  task automatic test_reset_busy();
    set_idle();
    mr = 1; rw = 1; alu = 32'h300;
    tick();
    total++; if (ram_req !== 1'b1) begin bad++; $display("FAIL rb_req got=%0b exp=1", ram_req); end
    tick();
    set_idle();
    rst = 1;
    tick();
    rst = 0;
    total++; if (ram_req !== 1'b0 || ram_addr !== 30'h0) begin bad++; $display("FAIL rb_clear got=%0b/%h exp=0/0", ram_req, ram_addr); end
    total++; if ({mis_err, to_err} !== 2'b00) begin bad++; $display("FAIL rb_flags got=%b exp=00", {mis_err, to_err}); end
    ack = 1; rdata = 32'hABCD;
    #1;
    total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL rb_stall got=%0b exp=0", mem_stall); end
    tick();
    set_idle();
    total++; if (ram_req !== 1'b0 || rw_wb !== 1'b0 || rdata_wb !== 32'h0) begin bad++; $display("FAIL rb_lateack got=%0b/%0b/%h exp=0/0/0", ram_req, rw_wb, rdata_wb); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw();
    test_sw();
    test_misalign();
    test_halt();
    test_timeout();
    test_ack_idle();
    test_reset_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
